// File: rtl/trace_unpack.sv
// Trace FIFO consumer: passes samples through and expands overflow markers into gap beats,
// tagging every beat with a running sequence number. Optional statistics: TRACE_UNPACK_STATS_EN.
module trace_unpack #(
    parameter int sample_width_p  = 16,
    parameter int counter_width_p = 16,
    parameter int seq_width_p     = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [sample_width_p:0]   fifo_data,
    input  logic                      fifo_valid,
    output logic                      fifo_ready,
    output logic [sample_width_p-1:0] out_data,
    output logic                      out_gap,
    output logic [seq_width_p-1:0]    out_seq,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      proto_err
`ifdef TRACE_UNPACK_STATS_EN
    ,
    output logic [seq_width_p-1:0]    stat_samples,
    output logic [seq_width_p-1:0]    stat_drops
`endif
);

    // state  | meaning
    // IDLE   | accepting FIFO words
    // EXPAND | emitting the remaining gap beats of a marker, input stalled
    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [counter_width_p-1:0] cnt_one = {{(counter_width_p-1){1'b0}}, 1'b1};
    localparam logic [seq_width_p-1:0]     seq_one = {{(seq_width_p-1){1'b0}}, 1'b1};

    state_t                      state;
    state_t                      state_next;
    logic [counter_width_p-1:0]  remaining;
    logic [counter_width_p-1:0]  remaining_next;
    logic [seq_width_p-1:0]      seq_cnt;
    logic [counter_width_p-1:0]  marker_d;

    logic accept;
    logic is_marker;
    logic can_load;
    logic retire;
    logic load_sample;
    logic load_gap;
    logic err_set;

    assign can_load   = ~out_valid | out_ready;
    assign retire     = out_valid & out_ready;
    // Gated by reset_n so the port reads 0 while reset is held
    assign fifo_ready = reset_n & (state == IDLE) & can_load;
    assign accept     = fifo_valid & fifo_ready;
    assign is_marker  = fifo_data[sample_width_p];
    assign marker_d   = fifo_data[counter_width_p-1:0] - cnt_one;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_marker && (marker_d > cnt_one)) begin
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (can_load && (remaining == cnt_one)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_sample    = 1'b0;
        load_gap       = 1'b0;
        err_set        = 1'b0;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_marker) begin
                        load_sample = 1'b1;
                    end else if (marker_d == '0) begin
                        err_set = 1'b1;
                    end else begin
                        load_gap       = 1'b1;
                        remaining_next = marker_d - cnt_one;
                    end
                end
            end
            EXPAND: begin
                if (can_load) begin
                    load_gap       = 1'b1;
                    remaining_next = remaining - cnt_one;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            seq_cnt   <= '0;
            out_data  <= '0;
            out_gap   <= 1'b0;
            out_seq   <= '0;
            out_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            remaining <= remaining_next;
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (load_sample || load_gap) begin
                out_data  <= load_sample ? fifo_data[sample_width_p-1:0] : '0;
                out_gap   <= load_gap;
                out_seq   <= seq_cnt;
                out_valid <= 1'b1;
                seq_cnt   <= seq_cnt + seq_one;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TRACE_UNPACK_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_samples <= '0;
            stat_drops   <= '0;
        end else if (retire) begin
            if (out_gap) begin
                if (stat_drops != '1) stat_drops <= stat_drops + seq_one;
            end else begin
                if (stat_samples != '1) stat_samples <= stat_samples + seq_one;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trace_unpack.sv
// Self-checking bench for trace_unpack: directed scenarios plus randomized traffic against a beat-queue model.
module tb_trace_unpack;
    localparam int SW = 16;
    localparam int CW = 4;
    localparam int QW = 8;

    typedef struct packed {
        logic [SW-1:0] data;
        logic          gap;
        logic [QW-1:0] seq;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [SW:0]   fifo_data = '0;
    logic          fifo_valid = 1'b0;
    logic          fifo_ready;
    logic [SW-1:0] out_data;
    logic          out_gap;
    logic [QW-1:0] out_seq;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          proto_err;
`ifdef TRACE_UNPACK_STATS_EN
    logic [QW-1:0] stat_samples;
    logic [QW-1:0] stat_drops;
    int            exp_samples = 0;
    int            exp_drops = 0;
`endif

    trace_unpack #(.sample_width_p(SW), .counter_width_p(CW), .seq_width_p(QW)) dut (
        .clk(clk), .reset_n(reset_n),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .out_data(out_data), .out_gap(out_gap), .out_seq(out_seq),
        .out_valid(out_valid), .out_ready(out_ready), .proto_err(proto_err)
`ifdef TRACE_UNPACK_STATS_EN
        , .stat_samples(stat_samples), .stat_drops(stat_drops)
`endif
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    exp_seq = 0;
    bit    exp_err = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    retired = 0;
    bit    rand_ready = 1'b0;
    beat_t held;
    bit    held_v = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Model: a word becomes a list of expected beats, derived from the marker arithmetic rules
    task automatic model_word(input logic [SW:0] w);
        int    p;
        int    d;
        beat_t b;
        if (!w[SW]) begin
            b.data = w[SW-1:0];
            b.gap  = 1'b0;
            b.seq  = exp_seq[QW-1:0];
            exp_q.push_back(b);
            exp_seq = (exp_seq + 1) % (1 << QW);
        end else begin
            p = int'(w[CW-1:0]);
            d = (p == 0) ? (1 << CW) - 1 : p - 1;
            if (d == 0) exp_err = 1'b1;
            for (int i = 0; i < d; i++) begin
                b.data = '0;
                b.gap  = 1'b1;
                b.seq  = exp_seq[QW-1:0];
                exp_q.push_back(b);
                exp_seq = (exp_seq + 1) % (1 << QW);
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_seq = 0;
        exp_err = 1'b0;
`ifdef TRACE_UNPACK_STATS_EN
        exp_samples = 0;
        exp_drops = 0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_ready"}, fifo_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_gap"}, out_gap, 0);
        check({tag, "_out_seq"}, out_seq, 0);
        check({tag, "_proto_err"}, proto_err, 0);
`ifdef TRACE_UNPACK_STATS_EN
        check({tag, "_stat_samples"}, stat_samples, 0);
        check({tag, "_stat_drops"}, stat_drops, 0);
`endif
    endtask

    task automatic push(input logic [SW:0] w);
        int n = 0;
        @(negedge clk);
        fifo_data  = w;
        fifo_valid = 1'b1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        forever begin
            #1;
            if (fifo_ready) begin
                @(posedge clk);
                break;
            end
            n++;
            if (n > 500) begin
                timeout_fail("push");
                fifo_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        #1 fifo_valid = 1'b0;
        model_word(w);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            n++;
            if (n > 3000) begin
                timeout_fail("drain");
                break;
            end
        end
        check("drain_out_valid", out_valid, 0);
`ifdef TRACE_UNPACK_STATS_EN
        check("stat_samples", stat_samples, exp_samples);
        check("stat_drops", stat_drops, exp_drops);
`endif
    endtask

    // Monitor: sampled mid-low-phase; a beat seen with valid&ready retires on the coming edge
    always @(negedge clk) begin
        beat_t obs;
        #3;
        if (reset_n) begin
            check("proto_err", proto_err, exp_err);
            if (out_valid) begin
                obs = {out_data, out_gap, out_seq};
                if (held_v) check("hold_stable", obs, held);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_beat observed=%0h expected=none", obs);
                end else begin
                    check("beat", obs, exp_q[0]);
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    retired++;
`ifdef TRACE_UNPACK_STATS_EN
                    if (obs.gap) begin
                        if (exp_drops < (1 << QW) - 1) exp_drops++;
                    end else begin
                        if (exp_samples < (1 << QW) - 1) exp_samples++;
                    end
`endif
                    held_v = 1'b0;
                end else begin
                    held   = obs;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int r;
        logic [SW:0] w;

        // Reset state
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Single sample, one-cycle latency
        push(17'h0_1234);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 16'h1234);
        check("t1_gap", out_gap, 0);
        check("t1_seq", out_seq, 0);

        // Marker P=4: three gap beats, input stalled during expansion
        push(17'h1_0004);
        check("t2_ready_a", fifo_ready, 0);
        @(posedge clk); #1;
        check("t2_ready_b", fifo_ready, 0);
        @(posedge clk); #1;
        check("t2_ready_c", fifo_ready, 1);
        drain();

        // Wrapped producer counter: P=0 gives 15 gaps
        @(negedge clk); reset_n = 1'b0; model_reset();
        @(negedge clk); reset_n = 1'b1;
        push(17'h1_0000);
        push(17'h0_00ab);
        drain();
        check("t3_last_seq", out_seq, 15);
        // Upper bits ignored (low nibble 4), and D=1 stays in IDLE
        push(17'h1_0064);
        push(17'h1_0002);
        check("t3_d1_ready", fifo_ready, 1);
        push(17'h0_5a5a);
        drain();

        // Illegal marker P=1
        push(17'h1_0001);
        check("t4_err", proto_err, 1);
        check("t4_no_beat", out_valid, 0);
        push(17'h0_0777);
        push(17'h1_0003);
        drain();
        check("t4_err_sticky", proto_err, 1);

        // Stall with marker P=3
        @(negedge clk); out_ready = 1'b0;
        push(17'h1_0003);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t5_ready_stall", fifo_ready, 0);
            check("t5_valid_stall", out_valid, 1);
        end
        drain();
        check("t5_idle_ready", fifo_ready, 1);

        // Reset mid-expansion
        base = retired;
        push(17'h1_0000);
        n = 0;
        while (retired - base < 10) begin
            @(negedge clk); #4;
            n++;
            if (n > 200) begin
                timeout_fail("t6_wait");
                break;
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        #1 check_all_zero("t6_reset");
        @(negedge clk); reset_n = 1'b1;
        push(17'h0_4321);
        check("t6_seq", out_seq, 0);
        drain();

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            w = 17'($urandom);
            if (r < 70) begin
                w[SW] = 1'b0;
            end else if (r < 97) begin
                w[SW] = 1'b1;
                if (w[CW-1:0] == 4'd1) w[CW-1:0] = 4'd5;
            end else begin
                w[SW] = 1'b1;
                w[CW-1:0] = 4'd1;
            end
            push(w);
            if ($urandom_range(0, 7) == 0) begin
                repeat (int'($urandom_range(1, 3))) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        drain();
        rand_ready = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
